arb_32_8: RTL and testbench

ARB_32_8 -- requirements
Module: arb_32_8

---
 rtl/arb_32_8.sv | 92 +++++++++
 tb/tb_arb_32_8.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/arb_32_8.sv
// Four-requester word arbiter that serializes the winning 32-bit word MSB byte first.
// Define ARB_32_8_FIXED_PRIO_EN for fixed priority (req[0] highest) instead of round-robin.
module arb_32_8 (
  input  logic         clk,
  input  logic         reset,
  input  logic [3:0]   req,
  input  logic [127:0] in_data128,
  output logic [3:0]   gnt,
  output logic [7:0]   out_data8,
  output logic         out8,
  output logic         busy
);

  typedef enum logic {StIdle, StSend} state_e;

  state_e      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [1:0]  ptr_q, ptr_d;
  logic [31:0] shift_q, shift_d;

  logic        arb_pt;
  logic [1:0]  win;
  logic        win_vld;

`ifdef ARB_32_8_FIXED_PRIO_EN
  always_comb begin
    win     = 2'd0;
    win_vld = |req;
    for (int i = 3; i >= 0; i--) begin
      if (req[i]) win = 2'(i);
    end
  end
`else
  logic [1:0] idx;

  // First requester at or after ptr, wrapping mod 4.
  always_comb begin
    win     = 2'd0;
    win_vld = 1'b0;
    idx     = 2'd0;
    for (int k = 0; k < 4; k++) begin
      idx = ptr_q + 2'(k);
      if (!win_vld && req[idx]) begin
        win     = idx;
        win_vld = 1'b1;
      end
    end
  end
`endif

  assign arb_pt = (state_q == StIdle) || (cnt_q == 2'd3);

  always_comb begin
    state_d = state_q;
    cnt_d   = (state_q == StSend) ? cnt_q + 2'd1 : 2'd0;
    shift_d = {shift_q[23:0], 8'h00};
    ptr_d   = ptr_q;
    gnt     = 4'b0000;
    if (arb_pt) begin
      cnt_d = 2'd0;
      if (win_vld) begin
        state_d = StSend;
        shift_d = in_data128[{win, 5'b00000} +: 32];
        ptr_d   = win + 2'd1;
        // Grant is visible during the cycle whose closing edge captures the word.
        gnt     = reset ? (4'b0001 << win) : 4'b0000;
      end else begin
        state_d = StIdle;
        shift_d = 32'h0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      cnt_q   <= 2'd0;
      ptr_q   <= 2'd0;
      shift_q <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      shift_q <= shift_d;
    end
  end

  assign busy      = (state_q == StSend);
  assign out8      = busy;
  assign out_data8 = out8 ? shift_q[31:24] : 8'h00;

endmodule

// File: tb/tb_arb_32_8.sv
// Scoreboard bench for arb_32_8: stimulus queues expected grants/bytes, a monitor checks them.
module tb_arb_32_8;

  logic         clk;
  logic         reset;
  logic [3:0]   req;
  logic [127:0] in_data128;
  logic [3:0]   gnt;
  logic [7:0]   out_data8;
  logic         out8;
  logic         busy;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] exp_byte[$];
  logic [3:0] exp_gnt[$];

  arb_32_8 dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .in_data128 (in_data128),
    .gnt        (gnt),
    .out_data8  (out_data8),
    .out8       (out8),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input int lane, input logic [31:0] data);
    exp_gnt.push_back(4'(4'b0001 << lane));
    for (int b = 3; b >= 0; b--) exp_byte.push_back(data[8*b +: 8]);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    req   = 4'b1111;
    #2;
    check("rst_gnt", 32'(gnt), 32'h0);
    check("rst_out8", 32'(out8), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_data", 32'(out_data8), 32'h0);
    req = 4'b0000;
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  // Monitor: sample at the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (reset) begin
      check("gnt_onehot", 32'($countones(gnt) <= 1), 32'h1);
      if (!out8) check("idle_byte_zero", 32'(out_data8), 32'h0);
      if (gnt != 4'b0000) begin
        if (exp_gnt.size() == 0) check("gnt_unexpected", 32'(gnt), 32'h0);
        else check("gnt", 32'(gnt), 32'(exp_gnt.pop_front()));
      end
      if (out8) begin
        if (exp_byte.size() == 0) check("byte_unexpected", 32'(out_data8), 32'hxx);
        else check("byte", 32'(out_data8), 32'(exp_byte.pop_front()));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int gaps;
    int budget;
    reset      = 1'b0;
    req        = 4'b0000;
    in_data128 = '0;

    // Reset two bytes into 12345678: remaining bytes must vanish.
    do_reset();
    in_data128[31:0] = 32'h12345678;
    req = 4'b0001;
    exp_gnt.push_back(4'b0001);
    exp_byte.push_back(8'h12);
    exp_byte.push_back(8'h34);
    tick();
    req = 4'b0000;
    tick();
    @(negedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("async_out8", 32'(out8), 32'h0);
    check("async_busy", 32'(busy), 32'h0);
    check("async_data", 32'(out_data8), 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    tick();
    tick();
    check("post_rst_out8", 32'(out8), 32'h0);
    check("post_rst_busy", 32'(busy), 32'h0);
    check("post_rst_gnt", 32'(gnt), 32'h0);

    // Reset mid-word, then a fresh word arbitrated right after release.
    in_data128[31:0] = 32'hAABBCCDD;
    req = 4'b0001;
    exp_gnt.push_back(4'b0001);
    exp_byte.push_back(8'hAA);
    tick();
    req = 4'b0000;
    @(negedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("mid_rst_out8", 32'(out8), 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    in_data128[31:0] = 32'hDDDDDDDD;
    req = 4'b0001;
    push_word(0, 32'hDDDDDDDD);
    tick();
    req = 4'b0000;
    repeat (5) tick();
    check("dd_done_out8", 32'(out8), 32'h0);
    check("dd_done_busy", 32'(busy), 32'h0);

    // All four requesting continuously.
    do_reset();
    for (int i = 0; i < 4; i++)
      in_data128[32*i +: 32] = (32'h0000_0010 * i) | {4{8'(8'hA0 + i)}};
`ifdef ARB_32_8_FIXED_PRIO_EN
    for (int g = 0; g < 5; g++) push_word(0, 32'hA0A0A0A0);
`else
    push_word(0, 32'hA0A0A0A0);
    push_word(1, 32'hA1A1A1B1);
    push_word(2, 32'hA2A2A2A2);
    push_word(3, 32'hA3A3A3B3);
    push_word(0, 32'hA0A0A0A0);
`endif
    req  = 4'b1111;
    gaps = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (i == 17) req = 4'b0000;
      if (!out8) gaps++;
    end
    check("rr_no_gap", 32'(gaps), 32'h0);
    tick();
    check("rr_end_out8", 32'(out8), 32'h0);

    // Late request held pending until the next arbitration point.
    do_reset();
    in_data128 = '0;
    in_data128[31:0] = 32'hFFFFFFFF;
    req = 4'b0001;
    push_word(0, 32'hFFFFFFFF);
    push_word(2, 32'h00000003);
    tick();
    req = 4'b0000;
    tick();
    in_data128[95:64] = 32'h00000003;
    req = 4'b0100;
    tick();
    tick();
    tick();
    req = 4'b0000;
    repeat (5) tick();
    check("late_busy", 32'(busy), 32'h0);

    budget = 0;
    while ((exp_byte.size() != 0 || exp_gnt.size() != 0) && budget < 50) begin
      tick();
      budget++;
    end
    check("byte_q_empty", 32'(exp_byte.size()), 32'h0);
    check("gnt_q_empty", 32'(exp_gnt.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
